// File: rtl/lfsr_stream_checker.sv
// lfsr_stream_checker
//   Self-synchronising checker for the 16-bit PRNG stream with feedback
//   f(s) = s[15]^s[14]^s[12]^s[3] and update s <= {s[14:0], bit}.
//   It loads 16 received bits as a seed, verifies LOCK_COUNT predicted bits,
//   then stays LOCKED and counts prediction errors until too many errors
//   fall inside one WINDOW-bit observation window.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   bit_in     in   received stream bit
//   bit_valid  in   qualifies bit_in
//   clear      in   synchronous clear of err_cnt / bit_cnt (wins over increment)
//   locked     out  high while in LOCKED
//   state      out  0=SEED, 1=VERIFY, 2=LOCKED
//   err_pulse  out  one-cycle pulse per mismatch seen in LOCKED
//   err_cnt    out  saturating mismatch count (LOCKED only)
//   bit_cnt    out  saturating count of bits checked in LOCKED
module lfsr_stream_checker #(
  parameter int LOCK_COUNT  = 32,
  parameter int WINDOW      = 64,
  parameter int LOSS_THRESH = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clear,
  output logic             locked,
  output logic [1:0]       state,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] bit_cnt
);

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [7:0] LOCK_C = 8'(LOCK_COUNT);
  localparam logic [7:0] WIN_C  = 8'(WINDOW);
  localparam logic [7:0] LOSS_C = 8'(LOSS_THRESH);

  state_t           st_q, st_d;
  logic [15:0]      s_q, s_d;
  logic [3:0]       seed_cnt_q, seed_cnt_d;
  logic [7:0]       match_q, match_d;
  logic [7:0]       win_bit_q, win_bit_d;
  logic [7:0]       win_err_q, win_err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             err_pulse_q, err_pulse_d;
  logic             locked_q;

  logic             exp_bit;
  logic             mism;
  logic [7:0]       win_err_inc;

  function automatic logic lfsr_fb(input logic [15:0] s);
    return s[15] ^ s[14] ^ s[12] ^ s[3];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign exp_bit     = lfsr_fb(s_q);
  assign mism        = bit_in ^ exp_bit;
  // win_err_q never exceeds LOSS_THRESH-1 (<=254), so +1 cannot overflow 8 bits.
  assign win_err_inc = win_err_q + {7'd0, mism};

  always_comb begin
    st_d        = st_q;
    s_d         = s_q;
    seed_cnt_d  = seed_cnt_q;
    match_d     = match_q;
    win_bit_d   = win_bit_q;
    win_err_d   = win_err_q;
    err_cnt_d   = err_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    err_pulse_d = 1'b0;

    if (bit_valid) begin
      unique case (st_q)
        SEED: begin
          s_d = {s_q[14:0], bit_in};
          if (seed_cnt_q == 4'd15) begin
            seed_cnt_d = 4'd0;
            // An all-zero seed is the LFSR lock-up state: keep seeding.
            if (s_d != 16'd0) begin
              st_d    = VERIFY;
              match_d = 8'd0;
            end
          end else begin
            seed_cnt_d = seed_cnt_q + 4'd1;
          end
        end
        VERIFY: begin
          s_d = {s_q[14:0], exp_bit};
          if (mism) begin
            // The offending bit is dropped; seeding starts with the next one.
            st_d       = SEED;
            seed_cnt_d = 4'd0;
          end else if (match_q + 8'd1 == LOCK_C) begin
            st_d      = LOCKED;
            win_bit_d = 8'd0;
            win_err_d = 8'd0;
          end else begin
            match_d = match_q + 8'd1;
          end
        end
        LOCKED: begin
          s_d       = {s_q[14:0], exp_bit};
          bit_cnt_d = sat_inc(bit_cnt_q);
          if (mism) begin
            err_pulse_d = 1'b1;
            err_cnt_d   = sat_inc(err_cnt_q);
          end
          // Current bit's error is counted before the window rolls over.
          if (win_err_inc >= LOSS_C) begin
            st_d       = SEED;
            seed_cnt_d = 4'd0;
          end
          if (win_bit_q + 8'd1 == WIN_C) begin
            win_bit_d = 8'd0;
            win_err_d = 8'd0;
          end else begin
            win_bit_d = win_bit_q + 8'd1;
            win_err_d = win_err_inc;
          end
        end
        default: begin
          st_d       = SEED;
          seed_cnt_d = 4'd0;
        end
      endcase
    end

    if (clear) begin
      err_cnt_d = '0;
      bit_cnt_d = '0;
    end
  end

  // ---- register stage: all state and outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= SEED;
      s_q         <= 16'd0;
      seed_cnt_q  <= 4'd0;
      match_q     <= 8'd0;
      win_bit_q   <= 8'd0;
      win_err_q   <= 8'd0;
      err_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      err_pulse_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      st_q        <= st_d;
      s_q         <= s_d;
      seed_cnt_q  <= seed_cnt_d;
      match_q     <= match_d;
      win_bit_q   <= win_bit_d;
      win_err_q   <= win_err_d;
      err_cnt_q   <= err_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      err_pulse_q <= err_pulse_d;
      locked_q    <= (st_d == LOCKED);
    end
  end

  assign locked    = locked_q;
  assign state     = st_q;
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;
  assign bit_cnt   = bit_cnt_q;

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Testbench for lfsr_stream_checker: table of stream phases with expected
// end-of-phase status, plus hand-written sequences for zero stream, clear
// and asynchronous reset. CNT_W is reduced to 11 so saturation is reachable.
module tb_lfsr_stream_checker;

  localparam int CW = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          bit_in = 1'b0;
  logic          bit_valid = 1'b0;
  logic          clear = 1'b0;
  logic          locked;
  logic [1:0]    state;
  logic          err_pulse;
  logic [CW-1:0] err_cnt;
  logic [CW-1:0] bit_cnt;

  lfsr_stream_checker #(
    .LOCK_COUNT(32), .WINDOW(64), .LOSS_THRESH(8), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .clear(clear), .locked(locked), .state(state), .err_pulse(err_pulse),
    .err_cnt(err_cnt), .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [15:0] g;

  typedef struct {
    bit   rst;
    int   nbits;
    bit   gap;
    int   flip0;
    int   stride;
    int   nflip;
    int   exp_pulses;
    logic exp_locked;
    int   exp_state;
    int   exp_err;
    int   exp_bits;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(bit r, int n, bit gp, int f0, int st, int nf,
                              int p, logic l, int s, int e, int b);
    vec_t v;
    v.rst = r; v.nbits = n; v.gap = gp; v.flip0 = f0; v.stride = st;
    v.nflip = nf; v.exp_pulses = p; v.exp_locked = l; v.exp_state = s;
    v.exp_err = e; v.exp_bits = b;
    return v;
  endfunction

  task automatic chk(input string nm, input int id, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] actual=%0d required=%0d", nm, id, act, exp);
    end
  endtask

  // Reference PRNG generator, seeded 0xACE1.
  task automatic next_bit(output logic b);
    b = g[15] ^ g[14] ^ g[12] ^ g[3];
    g = {g[14:0], b};
  endtask

  task automatic step(input logic b, input logic v, input logic clr);
    @(negedge clk);
    bit_in = b; bit_valid = v; clear = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; bit_valid = 1'b0; clear = 1'b0; bit_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    g = 16'hACE1;
  endtask

  initial begin
    logic b;
    int   pulses;
    int   bad;

    //            rst n    gap f0  st nf p  l     s  err bits
    tbl[0]  = mk(1, 15,   0, 0,   1, 0, 0, 1'b0, 0, 0, 0);
    tbl[1]  = mk(0, 1,    0, 0,   1, 0, 0, 1'b0, 1, 0, 0);
    tbl[2]  = mk(0, 31,   0, 0,   1, 0, 0, 1'b0, 1, 0, 0);
    tbl[3]  = mk(0, 1,    0, 0,   1, 0, 0, 1'b1, 2, 0, 0);
    tbl[4]  = mk(0, 1000, 0, 0,   1, 0, 0, 1'b1, 2, 0, 1000);
    tbl[5]  = mk(0, 200,  0, 199, 1, 1, 1, 1'b1, 2, 1, 1200);
    tbl[6]  = mk(0, 16,   0, 0,   1, 0, 0, 1'b1, 2, 1, 1216);
    tbl[7]  = mk(0, 15,   0, 0,   2, 8, 8, 1'b0, 0, 9, 1231);
    tbl[8]  = mk(0, 47,   0, 0,   1, 0, 0, 1'b0, 1, 9, 1231);
    tbl[9]  = mk(0, 1,    0, 0,   1, 0, 0, 1'b1, 2, 9, 1231);
    tbl[10] = mk(0, 100,  1, 0,   1, 0, 0, 1'b1, 2, 9, 1331);
    tbl[11] = mk(0, 800,  0, 0,   1, 0, 0, 1'b1, 2, 9, 2047);
    tbl[12] = mk(1, 47,   1, 0,   1, 0, 0, 1'b0, 1, 0, 0);
    tbl[13] = mk(0, 1,    1, 0,   1, 0, 0, 1'b1, 2, 0, 0);
    tbl[14] = mk(0, 1000, 1, 0,   1, 0, 0, 1'b1, 2, 0, 1000);
    tbl[15] = mk(1, 16,   0, 0,   1, 0, 0, 1'b0, 1, 0, 0);
    tbl[16] = mk(0, 20,   0, 19,  1, 1, 0, 1'b0, 0, 0, 0);
    tbl[17] = mk(0, 47,   0, 0,   1, 0, 0, 1'b0, 1, 0, 0);
    tbl[18] = mk(0, 1,    0, 0,   1, 0, 0, 1'b1, 2, 0, 0);

    g = 16'hACE1;
    // Reset state, sampled while reset is held.
    #12;
    chk("rst_locked", 0, 32'(locked), 0);
    chk("rst_state", 0, 32'(state), 0);
    chk("rst_pulse", 0, 32'(err_pulse), 0);
    chk("rst_err", 0, 32'(err_cnt), 0);
    chk("rst_bits", 0, 32'(bit_cnt), 0);

    for (int p = 0; p < 19; p++) begin
      if (tbl[p].rst) do_reset();
      pulses = 0;
      for (int i = 0; i < tbl[p].nbits; i++) begin
        next_bit(b);
        if (tbl[p].nflip > 0 && i >= tbl[p].flip0 &&
            ((i - tbl[p].flip0) % tbl[p].stride) == 0 &&
            ((i - tbl[p].flip0) / tbl[p].stride) < tbl[p].nflip)
          b = ~b;
        step(b, 1'b1, 1'b0);
        if (err_pulse) pulses++;
        if (tbl[p].gap) begin
          step(1'b0, 1'b0, 1'b0);
          if (err_pulse) pulses++;
        end
      end
      chk("ph_locked", p, 32'(locked), 32'(tbl[p].exp_locked));
      chk("ph_state", p, 32'(state), tbl[p].exp_state);
      chk("ph_err_cnt", p, 32'(err_cnt), tbl[p].exp_err);
      chk("ph_bit_cnt", p, 32'(bit_cnt), tbl[p].exp_bits);
      chk("ph_pulses", p, pulses, tbl[p].exp_pulses);
    end

    // All-zero stream: must never leave SEED.
    do_reset();
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (state != 2'd0 || locked) bad++;
    end
    chk("zero_stream_leaves_seed", 0, bad, 0);

    // clear coincident with a LOCKED mismatch.
    do_reset();
    for (int i = 0; i < 48; i++) begin
      next_bit(b);
      step(b, 1'b1, 1'b0);
    end
    chk("pre_clear_locked", 0, 32'(locked), 1);
    for (int i = 0; i < 5; i++) begin
      next_bit(b);
      step(b, 1'b1, 1'b0);
    end
    chk("pre_clear_bits", 0, 32'(bit_cnt), 5);
    next_bit(b);
    step(~b, 1'b1, 1'b1);
    chk("clear_pulse", 0, 32'(err_pulse), 1);
    chk("clear_err", 0, 32'(err_cnt), 0);
    chk("clear_bits", 0, 32'(bit_cnt), 0);
    chk("clear_locked", 0, 32'(locked), 1);
    next_bit(b);
    step(b, 1'b1, 1'b0);
    chk("post_clear_pulse", 0, 32'(err_pulse), 0);
    chk("post_clear_bits", 0, 32'(bit_cnt), 1);

    // err_pulse lasts one cycle only, even across an idle cycle.
    next_bit(b);
    step(~b, 1'b1, 1'b0);
    chk("pulse_hi", 0, 32'(err_pulse), 1);
    chk("pulse_err", 0, 32'(err_cnt), 1);
    step(1'b0, 1'b0, 1'b0);
    chk("pulse_lo", 0, 32'(err_pulse), 0);
    chk("idle_bits", 0, 32'(bit_cnt), 2);

    // Asynchronous reset mid-lock: outputs clear without a clock edge.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_locked", 0, 32'(locked), 0);
    chk("arst_state", 0, 32'(state), 0);
    chk("arst_err", 0, 32'(err_cnt), 0);
    chk("arst_bits", 0, 32'(bit_cnt), 0);
    chk("arst_pulse", 0, 32'(err_pulse), 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/lfsr_stream_checker.md
# lfsr_stream_checker

Serial checker for the 16-bit LFSR pseudo-random stream produced by the team's PRNG generator. It self-synchronises to an incoming bit stream, then predicts every following bit and counts mismatches, giving lock status and bit-error statistics. It sits at the receive end of a PRNG loopback or link test and is driven one bit per valid cycle.

## Interface
Parameters:
- LOCK_COUNT, 32: consecutive correctly predicted bits needed after seeding to declare lock (1..255).
- WINDOW, 64: length, in valid bits, of the loss-of-lock observation window (2..255).
- LOSS_THRESH, 8: errors within one window that force loss of lock (1..WINDOW).
- CNT_W, 16: width of the error and bit counters.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- bit_in  in  1  received stream bit, sampled only when bit_valid=1.
- bit_valid  in  1  qualifies bit_in for this cycle.
- clear  in  1  synchronous clear of err_cnt and bit_cnt.
- locked  out  1  high while in LOCKED.
- state  out  2  debug: 0=SEED, 1=VERIFY, 2=LOCKED.
- err_pulse  out  1  one-cycle pulse per mismatch detected in LOCKED.
- err_cnt  out  CNT_W  mismatches counted in LOCKED, saturating.
- bit_cnt  out  CNT_W  valid bits checked in LOCKED, saturating.

## Operation
- Polynomial: next bit f(s) = s[15]^s[14]^s[12]^s[3]. Update: s <= {s[14:0], bit}. The stream is the sequence of bits shifted into s[0].
- Nothing changes on cycles with bit_valid=0, except clear.
- SEED: each valid bit shifts into s; 4-bit counter counts 16 bits. After the 16th bit, if the new s is 0x0000, stay in SEED and restart counting. Otherwise go to VERIFY with match counter 0.
- VERIFY: expected = f(s). s shifts in expected, not bit_in. On a match, the match counter increments. When it reaches LOCK_COUNT, go to LOCKED and clear the window counters. On a mismatch, go to SEED with the seed counter at 0. The mismatching bit is discarded, not used as the first seed bit. Errors in VERIFY do not touch err_cnt or err_pulse.
- LOCKED: expected = f(s), s shifts in expected. Every valid bit increments bit_cnt.
  - Mismatch: err_cnt increments and err_pulse fires.
  - Window bit counter counts to WINDOW. On the WINDOW-th bit, the window bit and window error counters reset to 0. The current bit's error is evaluated before that reset.
  - If the window error count, including the current bit, reaches LOSS_THRESH, go to SEED. bit_cnt and err_cnt are kept.
- Counters saturate at all-ones and never wrap.
- clear has priority over increment: on a clear cycle, err_cnt and bit_cnt become 0 even if a bit or error is also present. err_pulse still fires. clear does not affect state, s or the window counters.
- Reset: state=SEED, s=0, all counters 0, locked=0, err_pulse=0, err_cnt=0, bit_cnt=0.

## Timing
- All outputs are registered.
- err_pulse is high for exactly the cycle after the edge that sampled the erroneous bit.
- err_cnt and bit_cnt update on that same edge.
- locked rises at the edge sampling the (16+LOCK_COUNT)-th valid bit of a clean stream, so it is visible one cycle later. bit_valid gaps stretch this latency but do not change the bit count.
- locked falls at the edge sampling the bit that reaches LOSS_THRESH. That bit's err_pulse and err_cnt increment still occur.
- Back-to-back valid bits every cycle are supported; throughput is 1 bit/clk.
- rst_n assertion at any point, including mid-lock, clears everything asynchronously. Lock acquisition restarts from SEED after release.

## Test plan
- Clean stream from a generator seeded 0xACE1, bit_valid=1 continuously: locked=1 after exactly 48 valid bits, state=2. After 1000 further bits, err_cnt=0 and bit_cnt=1000.
- Same stream with bit_valid toggling 1/0: lock at the 48th valid bit (about cycle 96), and counts identical to the first test.
- Locked, flip stream bit 200: one err_pulse, err_cnt=1, locked stays 1. Flip 8 bits inside one 64-bit window: locked drops on the 8th, state=0, err_cnt=9. A clean resume re-locks after 48 bits.
- All-zero stream for 500 bits: state toggles only within SEED, locked never asserts.
- Mismatch injected at VERIFY bit 20: returns to SEED. Lock is achieved 16+32 bits after the restart, and err_cnt stays 0.
- clear asserted together with a LOCKED mismatch: err_pulse=1 but err_cnt=0 next cycle. rst_n pulsed mid-lock: all outputs 0 immediately.
